// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: load/store ctrl codes and FSM state codes.
// The CPU memory controller imports this package so both sides agree on the encodings.
package dmem_responder_pkg;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LB   = 3'd1;
    localparam logic [2:0] RD_LBU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LHU  = 3'd4;
    localparam logic [2:0] RD_LW   = 3'd5;
    localparam logic [2:0] RD_LWU  = 3'd6;
    localparam logic [2:0] RD_LD   = 3'd7;

    // Store codes above WR_SD are illegal and fault.
    localparam logic [2:0] WR_NONE = 3'd0;
    localparam logic [2:0] WR_SB   = 3'd1;
    localparam logic [2:0] WR_SH   = 3'd2;
    localparam logic [2:0] WR_SW   = 3'd3;
    localparam logic [2:0] WR_SD   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: load extract/extend, store byte merge and size-alignment check.
// Little-endian: lane n holds bits [8n+7:8n] of the 64-bit word.
module dmem_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    input  logic [2:0]  lane,
    input  logic [63:0] mem_word,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_word,
    output logic        align_err
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] byte_mask;
    logic [63:0] lane_mask;

    assign shamt   = {lane, 3'b000};
    assign shifted = mem_word >> shamt;

    always_comb begin
        load_data = '0;
        case (rd_ctrl)
            RD_LB:   load_data = {{56{shifted[7]}}, shifted[7:0]};
            RD_LBU:  load_data = {56'd0, shifted[7:0]};
            RD_LH:   load_data = {{48{shifted[15]}}, shifted[15:0]};
            RD_LHU:  load_data = {48'd0, shifted[15:0]};
            RD_LW:   load_data = {{32{shifted[31]}}, shifted[31:0]};
            RD_LWU:  load_data = {32'd0, shifted[31:0]};
            RD_LD:   load_data = shifted;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        byte_mask = '0;
        case (wr_ctrl)
            WR_SB:   byte_mask = 64'h0000_0000_0000_00FF;
            WR_SH:   byte_mask = 64'h0000_0000_0000_FFFF;
            WR_SW:   byte_mask = 64'h0000_0000_FFFF_FFFF;
            WR_SD:   byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            default: byte_mask = '0;
        endcase
    end

    assign lane_mask  = byte_mask << shamt;
    assign store_word = (mem_word & ~lane_mask) | ((wdata & byte_mask) << shamt);

    always_comb begin
        align_err = 1'b0;
        case (rd_ctrl)
            RD_LH, RD_LHU: align_err = lane[0];
            RD_LW, RD_LWU: align_err = |lane[1:0];
            RD_LD:         align_err = |lane;
            default:       align_err = 1'b0;
        endcase
        case (wr_ctrl)
            WR_SH:   align_err = align_err | lane[0];
            WR_SW:   align_err = align_err | (|lane[1:0]);
            WR_SD:   align_err = align_err | (|lane);
            default: align_err = align_err;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency and 64-bit word storage.
// Stores commit on the edge that enters RESP; a faulting request never touches storage.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | ready for a request; req_ready=1
//   WAIT    | request latched, down-counter running until latency elapses
//   RESP    | response held on resp_* until resp_ready
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_rd_ctrl,
    input  logic [2:0]  req_wr_ctrl,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  rd_q, rd_d;
    logic [2:0]  wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH];

    logic [2:0]       cur_rd, cur_wr;
    logic [63:0]      cur_addr, cur_wdata;
    logic [IDX_W-1:0] cur_idx;
    logic [63:0]      mem_word, load_data, store_word;
    logic             align_err, range_err, fault;
    logic             go_resp, mem_we;

    // With LATENCY=1 the response is formed in the accept cycle, straight from the request bus.
    assign cur_rd    = (state_q == ST_IDLE) ? req_rd_ctrl : rd_q;
    assign cur_wr    = (state_q == ST_IDLE) ? req_wr_ctrl : wr_q;
    assign cur_addr  = (state_q == ST_IDLE) ? req_addr    : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata   : wdata_q;

    assign cur_idx   = cur_addr[IDX_W+2:3];
    assign range_err = cur_addr[63:3] >= 61'(DEPTH);
    assign mem_word  = range_err ? 64'd0 : mem[cur_idx];

    dmem_lane_unit u_lane (
        .rd_ctrl    (cur_rd),
        .wr_ctrl    (cur_wr),
        .lane       (cur_addr[2:0]),
        .mem_word   (mem_word),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .align_err  (align_err)
    );

    assign fault = align_err | range_err | (cur_wr > WR_SD)
                 | ((cur_rd != RD_NONE) && (cur_wr != WR_NONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        go_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rd_d    = req_rd_ctrl;
                    wr_d    = req_wr_ctrl;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_resp) begin
            state_d = ST_RESP;
            err_d   = fault;
            rdata_d = (fault || (cur_wr != WR_NONE)) ? 64'd0 : load_data;
        end
    end

    assign mem_we = go_resp && !fault && (cur_wr != WR_NONE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= store_word;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
